key_debounce_n: RTL and testbench
=================================

# key_debounce_n

Parametrised multi-channel push-button conditioner. Each raw key input passes through a 2-flop synchroniser, a shared sample-tick divider and a per-channel N-consecutive-sample stability filter. Each channel produces a debounced level, single-cycle press and release pulses, a toggle state, and a long-press pulse. It sits between board switch pins and user logic such as LED control and mode selection.

## Interface
- N_KEYS, 3: number of independent channels (≥1).
- TICK_DIV, 1048576: clk cycles per sample tick (≥2); 2^20 ≈ 20 ms at 50 MHz.
- STABLE_SAMPLES, 3: consecutive ticks a new level must persist before acceptance (≥1).
- LONG_TICKS, 50: ticks a key must stay pressed before key_long fires (≥1).
- ACTIVE_LOW, 1: 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low; clock clk.
- keys_in  in  N_KEYS  raw asynchronous switch pins.
- key_level  out  N_KEYS  debounced state, 1 = pressed (polarity-normalised).
- key_press  out  N_KEYS  1-cycle pulse on accepted press.
- key_release  out  N_KEYS  1-cycle pulse on accepted release.
- key_toggle  out  N_KEYS  flips on every accepted press.
- key_long  out  N_KEYS  1-cycle pulse once per press, after LONG_TICKS held ticks.

## Operation
- Synchroniser: 2 flops per channel. Reset value is the inactive pin level (all 1s if ACTIVE_LOW, else all 0s). Output is XOR'd with ACTIVE_LOW to give s[i], where 1 = pressed.
- Tick divider: one shared counter, width $clog2(TICK_DIV). It counts 0..TICK_DIV-1 and wraps. tick = (div == TICK_DIV-1), which holds for one clk cycle per period. No other logic advances between ticks.
- Stability filter, per channel, width $clog2(STABLE_SAMPLES+1). On a tick:
  - If s[i] == key_level[i]: cnt <= 0.
  - Else, if cnt+1 == STABLE_SAMPLES: key_level[i] <= s[i] and cnt <= 0. Pulse key_press[i] if s[i]=1, or key_release[i] if s[i]=0.
  - Else: cnt <= cnt+1.
  - Any bounce sample matching the current state restarts the count.
- Toggle: key_toggle[i] <= ~key_toggle[i] in the same edge that key_press[i] is set.
- Long press: hold[i], width $clog2(LONG_TICKS+1).
  - Cleared whenever key_level[i]=0.
  - On a tick with key_level[i]=1 and hold<LONG_TICKS: hold <= hold+1. When hold+1 == LONG_TICKS, pulse key_long[i].
  - hold saturates at LONG_TICKS, so there is no repeat until the key is released.
- Channels are fully independent. Simultaneous press or release on several channels in the same tick produces pulses in the same cycle.

## Timing
- Reset values: key_level=0, key_press=0, key_release=0, key_toggle=0, key_long=0, all counters 0.
- All outputs are registered. A pulse is high for exactly the one clk cycle following the tick edge that accepts it.
- Latency from a clean pin edge to key_press: 2 sync cycles plus the wait to the next tick, plus (STABLE_SAMPLES-1)·TICK_DIV cycles, plus 1 cycle.
- key_press and key_release are never high together on the same channel.
- The first key_long tick is the one after the accepting tick. key_long therefore fires LONG_TICKS ticks after key_press.
- Reset mid-operation immediately forces every output to its reset value, including a pulse that is in flight. After reset deasserts, the divider restarts from 0.
- Divider wrap: TICK_DIV-1 → 0, with no skipped or double ticks.

## Test plan
Bench parameters: N_KEYS=3, TICK_DIV=4, STABLE_SAMPLES=3, LONG_TICKS=5, ACTIVE_LOW=1.
- Reset then idle with keys_in=3'b111 for 100 cycles -> all outputs stay 0, and tick pulses every 4 cycles.
- Hold keys_in[0]=0 clean -> key_press[0] pulses once, 1 cycle wide, on the 3rd tick after sync. key_level[0]=1 and key_toggle[0]=1.
- Bounce keys_in[1] with the pattern 0,1,0,0,1,0,0,0, each value held for 4 cycles -> only the final 3-sample 0 run is accepted, giving exactly one key_press[1]. No pulses before that.
- Hold key 2 pressed for 10 ticks -> key_long[2] pulses once, 5 ticks after key_press[2], with no repeat. On release, key_release[2] fires 3 ticks later and hold is cleared. Pressing again produces a fresh key_long.
- Press keys 0 and 1 in the same cycle -> key_press[1:0]=2'b11 in the same cycle. Press key 0 twice -> key_toggle[0] returns to 0.
- Assert rst_n=0 while key_long is pending -> all outputs go to 0 immediately. After release of reset with the key still held, key_press fires again after the full latency.

Source files
------------

// File: rtl/key_debounce_n.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, shared sample-tick divider and
// per-channel stability filter producing level, press/release pulses, toggle and long-press.
module key_debounce_n #(
  parameter int unsigned N_KEYS         = 3,
  parameter int unsigned TICK_DIV       = 1048576,
  parameter int unsigned STABLE_SAMPLES = 3,
  parameter int unsigned LONG_TICKS     = 50,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_toggle,
  output logic [N_KEYS-1:0] key_long
);

  localparam int unsigned DivW  = $clog2(TICK_DIV);
  localparam int unsigned CntW  = $clog2(STABLE_SAMPLES + 1);
  localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);

  localparam logic [N_KEYS-1:0] IdlePins = ACTIVE_LOW ? '1 : '0;
  localparam logic [DivW-1:0]   DivMax   = DivW'(TICK_DIV - 1);
  localparam logic [CntW-1:0]   CntLast  = CntW'(STABLE_SAMPLES - 1);
  localparam logic [HoldW-1:0]  HoldMax  = HoldW'(LONG_TICKS);
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(LONG_TICKS - 1);

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] pressed;
  logic [DivW-1:0]   div_q, div_d;
  logic              tick;

  logic [N_KEYS-1:0]            level_q, level_d;
  logic [N_KEYS-1:0]            press_q, press_d;
  logic [N_KEYS-1:0]            release_q, release_d;
  logic [N_KEYS-1:0]            toggle_q, toggle_d;
  logic [N_KEYS-1:0]            long_q, long_d;
  logic [N_KEYS-1:0][CntW-1:0]  cnt_q, cnt_d;
  logic [N_KEYS-1:0][HoldW-1:0] hold_q, hold_d;

  // Normalise polarity so that 1 always means pressed downstream of the synchroniser.
  assign pressed = sync2_q ^ {N_KEYS{ACTIVE_LOW}};

  assign tick  = (div_q == DivMax);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    toggle_d  = toggle_q;
    long_d    = '0;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    for (int i = 0; i < N_KEYS; i++) begin
      if (tick) begin
        if (pressed[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          level_d[i] = pressed[i];
          cnt_d[i]   = '0;
          if (pressed[i]) begin
            press_d[i]  = 1'b1;
            toggle_d[i] = ~toggle_q[i];
          end else begin
            release_d[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      // The hold counter sees the pre-accept level, so counting starts on the tick after a press.
      if (!level_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && (hold_q[i] < HoldMax)) begin
        hold_d[i] = hold_q[i] + 1'b1;
        if (hold_q[i] == HoldLast) begin
          long_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= IdlePins;
      sync2_q   <= IdlePins;
      div_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
      long_q    <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
    end else begin
      sync1_q   <= keys_in;
      sync2_q   <= sync1_q;
      div_q     <= div_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      long_q    <= long_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_toggle  = toggle_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce_n.sv
// Scoreboard bench for key_debounce_n: expected pulse events are queued with their clock edge
// when pins are driven and matched against the pulses the DUT produces.
module tb_key_debounce_n;

  localparam int unsigned NK = 3;
  localparam int unsigned TD = 4;
  localparam int unsigned SS = 3;
  localparam int unsigned LT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] keys_in = 3'b111;
  logic [NK-1:0] key_level, key_press, key_release, key_toggle, key_long;

  key_debounce_n #(
    .N_KEYS        (NK),
    .TICK_DIV      (TD),
    .STABLE_SAMPLES(SS),
    .LONG_TICKS    (LT),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keys_in    (keys_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned   at;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
    logic [NK-1:0] lg;
  } ev_t;

  ev_t           sb_q[$];
  int unsigned   edge_n;
  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  logic [NK-1:0] lvl_m = '0;
  logic [NK-1:0] tog_m = '0;
  int unsigned   long_at[NK];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"}, 32'(key_level), 32'(lvl_m));
    check({tag, "_toggle"}, 32'(key_toggle), 32'(tog_m));
  endtask

  // First tick edge at or after the sync delay, then SS-1 further ticks to accept.
  function automatic int unsigned acc_edge(input int unsigned e);
    int unsigned t = e + 2;
    while (t % TD != 0) t++;
    return t + (SS - 1) * TD;
  endfunction

  task automatic expect_ev(input int unsigned at, input logic [NK-1:0] pr,
                           input logic [NK-1:0] rl, input logic [NK-1:0] lg);
    int  i = 0;
    ev_t ev;
    while (i < sb_q.size() && sb_q[i].at < at) i++;
    if (i < sb_q.size() && sb_q[i].at == at) begin
      ev    = sb_q[i];
      ev.pr = ev.pr | pr;
      ev.rl = ev.rl | rl;
      ev.lg = ev.lg | lg;
      sb_q[i] = ev;
    end else begin
      ev.at = at;
      ev.pr = pr;
      ev.rl = rl;
      ev.lg = lg;
      sb_q.insert(i, ev);
    end
  endtask

  // Pins change just before an edge two cycles ahead of a tick edge, so each value is sampled once.
  task automatic set_keys(input logic [NK-1:0] v, output int unsigned e);
    do @(negedge clk); while (edge_n % TD != 1);
    keys_in = v;
    e = edge_n + 1;
  endtask

  task automatic press_keys(input logic [NK-1:0] mask);
    int unsigned e, p;
    set_keys(keys_in & ~mask, e);
    p = acc_edge(e);
    expect_ev(p, mask, '0, '0);
    for (int ch = 0; ch < NK; ch++) begin
      if (mask[ch]) begin
        lvl_m[ch]   = 1'b1;
        tog_m[ch]   = ~tog_m[ch];
        long_at[ch] = p + LT * TD;
      end
    end
  endtask

  task automatic release_keys(input logic [NK-1:0] mask);
    int unsigned e, r;
    set_keys(keys_in | mask, e);
    r = acc_edge(e);
    expect_ev(r, '0, mask, '0);
    for (int ch = 0; ch < NK; ch++) begin
      if (mask[ch]) begin
        lvl_m[ch] = 1'b0;
        if (long_at[ch] > r) long_at[ch] = 0;
      end
    end
  endtask

  initial begin
    edge_n = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) edge_n = 0;
      else edge_n++;
    end
  end

  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int ch = 0; ch < NK; ch++) begin
          if (long_at[ch] != 0 && long_at[ch] == edge_n + 1) begin
            expect_ev(long_at[ch], '0, '0, NK'(1 << ch));
            long_at[ch] = 0;
          end
        end
        while (sb_q.size() > 0 && sb_q[0].at < edge_n) begin
          check("missed_event_edge", edge_n, sb_q[0].at);
          void'(sb_q.pop_front());
        end
        if (|{key_press, key_release, key_long}) begin
          if (sb_q.size() == 0) begin
            check("unexpected_pulse", 32'({key_press, key_release, key_long}), 32'd0);
          end else begin
            ev = sb_q.pop_front();
            check("ev_edge", edge_n, ev.at);
            check("ev_press", 32'(key_press), 32'(ev.pr));
            check("ev_release", 32'(key_release), 32'(ev.rl));
            check("ev_long", 32'(key_long), 32'(ev.lg));
          end
        end
      end
    end
  end

  initial begin
    int unsigned e;
    for (int ch = 0; ch < NK; ch++) long_at[ch] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check_state("idle");

    press_keys(3'b001);
    repeat (16) @(negedge clk);
    check_state("press0");

    // Bounce on key 1: 0,1,0,0,1 then a final settled 0 run.
    set_keys(3'b100, e);
    set_keys(3'b110, e);
    set_keys(3'b100, e);
    set_keys(3'b100, e);
    set_keys(3'b110, e);
    press_keys(3'b010);
    repeat (16) @(negedge clk);
    check_state("bounce1");

    press_keys(3'b100);
    repeat (40) @(negedge clk);
    check_state("hold2");
    release_keys(3'b100);
    repeat (16) @(negedge clk);
    check_state("release2");
    press_keys(3'b100);
    repeat (36) @(negedge clk);
    check_state("repress2");
    release_keys(3'b100);
    repeat (16) @(negedge clk);

    release_keys(3'b011);
    repeat (16) @(negedge clk);
    check_state("release01");
    press_keys(3'b011);
    repeat (12) @(negedge clk);
    check_state("dual_press");
    release_keys(3'b011);
    repeat (16) @(negedge clk);

    press_keys(3'b100);
    repeat (20) @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_level", 32'(key_level), 32'd0);
    check("rst_press", 32'(key_press), 32'd0);
    check("rst_release", 32'(key_release), 32'd0);
    check("rst_toggle", 32'(key_toggle), 32'd0);
    check("rst_long", 32'(key_long), 32'd0);
    sb_q.delete();
    lvl_m = '0;
    tog_m = '0;
    for (int ch = 0; ch < NK; ch++) long_at[ch] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Key 2 is still held: the synchroniser sees it from the first edge after reset.
    e = acc_edge(1);
    expect_ev(e, 3'b100, '0, '0);
    lvl_m[2]   = 1'b1;
    tog_m[2]   = 1'b1;
    long_at[2] = e + LT * TD;
    repeat (40) @(negedge clk);
    check_state("after_reset");
    release_keys(3'b100);
    repeat (16) @(negedge clk);
    check_state("final");
    check("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
